// File: rtl/cpu_regfile_sb_pkg.sv
// Shared types and constants for the register file with busy-bit scoreboard.
// Used by cpu_regfile_sb and cpu_regfile_sb_scoreboard.
package cpu_regfile_sb_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int ZERO_IDX    = 0;
  localparam int READ_N_MAX  = 8;
  localparam int WRITE_N_MAX = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/cpu_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: per-register in-flight producer flags plus a registered
// count of busy entries. Priority per edge: flush > alloc > write-back clear.
module cpu_regfile_sb_scoreboard
  import cpu_regfile_sb_pkg::*;
#(
  parameter int ADDR     = ADDR_W,
  parameter int WRITE    = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       alloc_,
  input  logic [ADDR-1:0]            alloc_addr,
  input  logic [WRITE-1:0]           we_,
  input  logic [WRITE-1:0][ADDR-1:0] waddr,
  input  logic                       flush_,
  output logic [(2**ADDR)-1:0]       busy,
  output logic [ADDR:0]              busy_cnt
);

  localparam int DEPTH = 2 ** ADDR;

  logic [DEPTH-1:0] r_busy;
  logic [ADDR:0]    r_cnt;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR:0]    w_cnt_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < WRITE; i++) begin
      if (!we_[i]) w_busy_nxt[waddr[i]] = 1'b0;
    end
    // A new producer issued this cycle outlives any completing write-back.
    if (!flush_) w_busy_nxt = '0;
    else if (!alloc_) w_busy_nxt[alloc_addr] = 1'b1;
    if (ZERO_REG) w_busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR{1'b0}}, w_busy_nxt[j]};
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

// File: rtl/cpu_regfile_sb.sv
// Multi-port register file with integrated busy-bit scoreboard.
// Define CPU_REGFILE_BYPASS_EN to forward same-cycle write-back data to read ports.
module cpu_regfile_sb
  import cpu_regfile_sb_pkg::*;
#(
  parameter int DATA     = DATA_W,
  parameter int ADDR     = ADDR_W,
  parameter int READ     = 2,
  parameter int WRITE    = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic [READ-1:0][ADDR-1:0]  raddr,
  output logic [READ-1:0][DATA-1:0]  rdata,
  output logic [READ-1:0]            rbusy,
  input  logic                       alloc_,
  input  logic [ADDR-1:0]            alloc_addr,
  input  logic [WRITE-1:0]           we_,
  input  logic [WRITE-1:0][ADDR-1:0] waddr,
  input  logic [WRITE-1:0][DATA-1:0] wdata,
  input  logic                       flush_,
  output logic [ADDR:0]              busy_cnt
);

  localparam int DEPTH = 2 ** ADDR;

  logic [DATA-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;

  cpu_regfile_sb_scoreboard #(
    .ADDR     (ADDR),
    .WRITE    (WRITE),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset_     (reset_),
    .alloc_     (alloc_),
    .alloc_addr (alloc_addr),
    .we_        (we_),
    .waddr      (waddr),
    .flush_     (flush_),
    .busy       (w_busy),
    .busy_cnt   (busy_cnt)
  );

  // Ascending port loop: the highest-indexed port's assignment lands last.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      for (int i = 0; i < WRITE; i++) begin
        if (!we_[i] && !(ZERO_REG && waddr[i] == ADDR'(ZERO_IDX))) begin
          r_mem[waddr[i]] <= wdata[i];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < READ; r++) begin
      rdata[r] = r_mem[raddr[r]];
      rbusy[r] = w_busy[raddr[r]];
`ifdef CPU_REGFILE_BYPASS_EN
      for (int i = 0; i < WRITE; i++) begin
        if (!we_[i] && waddr[i] == raddr[r]) begin
          rdata[r] = wdata[i];
          rbusy[r] = 1'b0;
        end
      end
`endif
      if (ZERO_REG && raddr[r] == ADDR'(ZERO_IDX)) begin
        rdata[r] = '0;
        rbusy[r] = 1'b0;
      end
    end
  end

endmodule
